// File: rtl/sram_output_reader.sv
// sram_output_reader
//   Drains a contiguous address range of the output-result SRAM onto a
//   valid/ready stream. Reads are issued against a credit count so the
//   return FIFO can never overflow, and the stream supports full backpressure.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle command pulse, honoured only when idle
//   base_addr, length   first word address and word count (0..DEPTH)
//   busy, done          transfer in progress / one-cycle completion pulse
//   sram_cen_n          SRAM chip enable (active low), registered
//   sram_wen            SRAM write enable, always 0
//   sram_addr           SRAM address, registered
//   sram_rdata          SRAM data_out (valid the cycle after cen_n=0)
//   out_valid, out_ready, out_data   result stream (out_data = FIFO head)
module sram_output_reader #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  sram_cen_n,
  output logic                  sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);
  localparam int LW = ADDR_WIDTH + 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW:0]   CREDITS  = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
  localparam logic [LW-1:0] MAX_LEN  = LW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LW-1:0]         len_q, issued_q, popped_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  // vld_pipe_q[0]: read presented to the SRAM this cycle (drives cen_n)
  // vld_pipe_q[1]: its data is on sram_rdata this cycle (push)
  logic [1:0]            vld_pipe_q;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         cnt_q;

  logic                  push, pop, issue_d;
  logic [1:0]            inflight;
  logic [CW:0]           occ;
  logic [ADDR_WIDTH-1:0] issue_addr_d;

  assign push      = vld_pipe_q[1];
  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid & out_ready;
  assign out_data  = mem_q[rd_ptr_q];
  assign inflight  = 2'(vld_pipe_q[0]) + 2'(vld_pipe_q[1]);
  // Occupancy seen by the credit check: a pop this cycle is not counted back.
  assign occ       = (CW+1)'(cnt_q) + (CW+1)'(inflight);

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign sram_cen_n = ~vld_pipe_q[0];
  assign sram_wen   = 1'b0;
  assign sram_addr  = addr_q;

  // The first read is launched straight from IDLE so cen_n drops in the
  // cycle right after start is sampled.
  always_comb begin
    issue_d      = 1'b0;
    issue_addr_d = base_q + issued_q[ADDR_WIDTH-1:0];
    if (state_q == S_IDLE) begin
      issue_d      = start && (length != '0);
      issue_addr_d = base_addr;
    end else if (state_q == S_RUN) begin
      issue_d = (issued_q < len_q) && (occ < CREDITS);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      addr_q     <= '0;
      vld_pipe_q <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[0], issue_d};
      if (issue_d) begin
        addr_q   <= issue_addr_d;
        issued_q <= (state_q == S_IDLE) ? LW'(1) : issued_q + LW'(1);
      end
      case (state_q)
        S_IDLE: if (start) begin
          base_q   <= base_addr;
          len_q    <= length;
          popped_q <= '0;
          state_q  <= (length == '0) ? S_DONE : S_RUN;
        end
        S_RUN: if (pop) begin
          popped_q <= popped_q + LW'(1);
          if (popped_q + LW'(1) == len_q) state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= sram_rdata;
        wr_ptr_q        <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // The credit rule must make a push into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && cnt_q == FULL));
  a_len_range: assert property (@(posedge clk) disable iff (!rst_n)
    !(start && state_q == S_IDLE && length > MAX_LEN));
endmodule

// File: tb/tb_sram_output_reader.sv
module tb_sram_output_reader;
  localparam int DW = 64, AW = 10, DEPTH = 1024, FD = 4;

  logic          clk = 1'b0;
  logic          rst_n, start, busy, done, sram_cen_n, sram_wen, out_valid, out_ready;
  logic [AW-1:0] base_addr, sram_addr;
  logic [AW:0]   length;
  logic [DW-1:0] sram_rdata = '0, out_data;

  always #5 clk = ~clk;

  sram_output_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .sram_cen_n(sram_cen_n), .sram_wen(sram_wen),
    .sram_addr(sram_addr), .sram_rdata(sram_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data));

  // SRAM model: 1-cycle read latency, output holds while deselected.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (!sram_cen_n && !sram_wen) sram_rdata <= mem[sram_addr];

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask
  task automatic fail_now(input string nm);
    n_chk++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  // ---------------- behavioural reference model + per-cycle compare ----------
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int m_busy = 0, m_done = 0, m_left = 0, issued = 0, popped = 0;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk) begin : model
    int nb, nd;
    logic hs;
    if (!rst_n) begin
      exp_q.delete(); exp_addr_q.delete();
      m_busy = 0; m_done = 0; m_left = 0; issued = 0; popped = 0; prev_stall = 1'b0;
    end else begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("wen", sram_wen, 0);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
      end
      if (!sram_cen_n) begin
        if (exp_addr_q.size() == 0) fail_now("unexpected_read");
        else chk("addr", sram_addr, exp_addr_q.pop_front());
        issued++;
        // reads presented minus words already taken never exceed the buffer
        chk("credit", (issued - popped) <= FD, 1);
      end
      hs = out_valid && out_ready;
      nb = m_busy; nd = 0;
      if (m_done) nb = 0;
      if (hs) begin
        if (exp_q.size() == 0) fail_now("unexpected_beat");
        else chk("data", out_data, exp_q.pop_front());
        popped++; m_left--;
        if (m_left == 0) nd = 1;
      end
      if (!m_busy && start) begin
        for (int i = 0; i < int'(length); i++) begin
          exp_q.push_back(mem[(int'(base_addr) + i) % DEPTH]);
          exp_addr_q.push_back(AW'((int'(base_addr) + i) % DEPTH));
        end
        m_left = int'(length); issued = 0; popped = 0;
        nb = 1;
        if (length == 0) nd = 1;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      m_busy = nb; m_done = nd;
    end
  end

  // ---------------- stimulus ----------------
  logic [AW-1:0] addr_log[$];
  logic [DW-1:0] first_data;
  int fv, dc, ncen, cfirst, clast;

  // rmode 0: ready=1, 1: random ready, 2: ready low in cycles slo..shi.
  // rcyc: cycle at which a second (to-be-ignored) start is pulsed.
  task automatic xfer(input int base, input int len, input int rmode,
                      input int slo, input int shi, input int rcyc);
    int cyc = 0;
    addr_log.delete();
    fv = -1; dc = -1; ncen = 0; cfirst = -1; clast = -1; first_data = '0;
    base_addr = AW'(base); length = (AW+1)'(len); start = 1'b1;
    out_ready = (rmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
    forever begin
      @(posedge clk); #1;
      start = 1'b0; cyc++;
      if (cyc == rcyc) begin start = 1'b1; base_addr = AW'(500); length = 3; end
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = !(cyc >= slo && cyc <= shi);
      endcase
      @(negedge clk);
      if (!sram_cen_n) begin
        ncen++; if (cfirst < 0) cfirst = cyc; clast = cyc;
        addr_log.push_back(sram_addr);
      end
      if (out_valid && fv < 0) begin fv = cyc; first_data = out_data; end
      if (done) begin dc = cyc; break; end
      if (cyc > 5000) begin fail_now("timeout_done"); break; end
    end
    @(posedge clk); #1;
    start = 1'b0; out_ready = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int hs_seen;
    for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom(), 16'($urandom()), 16'(i)};
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1;
    #12;
    chk("rst_cen_n", sram_cen_n, 1); chk("rst_addr", sram_addr, 0);
    chk("rst_valid", out_valid, 0);  chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);        chk("rst_done", done, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    idle(2);

    // single word
    xfer(5, 1, 0, 0, 0, 0);
    chk("b5_first_valid", fv, 3); chk("b5_done", dc, 4); chk("b5_ncen", ncen, 1);
    chk("b5_addr", addr_log[0], 5); chk("b5_data", first_data[15:0], 5);
    idle(2);

    // streaming, no gaps
    xfer(0, 16, 0, 0, 0, 0);
    chk("s16_first_valid", fv, 3); chk("s16_done", dc, 19);
    chk("s16_ncen", ncen, 16); chk("s16_cen_run", clast - cfirst, 15);
    idle(2);

    // backpressure window
    xfer(100, 20, 2, 5, 12, 0);
    chk("bp_done", dc, 31); chk("bp_ncen", ncen, 20);
    idle(2);

    // address wrap
    xfer(1022, 4, 0, 0, 0, 0);
    chk("wrap_ncen", ncen, 4);
    chk("wrap_a0", addr_log[0], 1022); chk("wrap_a1", addr_log[1], 1023);
    chk("wrap_a2", addr_log[2], 0);    chk("wrap_a3", addr_log[3], 1);
    idle(2);

    // zero length
    xfer(9, 0, 0, 0, 0, 0);
    chk("len0_done", dc, 1); chk("len0_ncen", ncen, 0); chk("len0_valid", fv, -1);
    idle(2);

    // start while busy, then start during DONE: both ignored
    xfer(300, 8, 0, 0, 0, 4);
    chk("busy_start_done", dc, 11); chk("busy_start_ncen", ncen, 8);
    xfer(7, 1, 0, 0, 0, 4);
    chk("done_start_done", dc, 4);
    idle(4);

    // abort with reset after 3 beats
    base_addr = AW'(200); length = 10; start = 1'b1; out_ready = 1'b1; hs_seen = 0;
    for (int c = 0; c < 50 && hs_seen < 3; c++) begin
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk); if (out_valid && out_ready) hs_seen++;
    end
    chk("abort_beats", hs_seen, 3);
    #2 rst_n = 1'b0; #1;
    chk("abort_cen_n", sram_cen_n, 1); chk("abort_addr", sram_addr, 0);
    chk("abort_valid", out_valid, 0);  chk("abort_data", out_data, 0);
    chk("abort_busy", busy, 0);        chk("abort_done", done, 0);
    repeat (3) begin @(negedge clk); chk("abort_hold_done", done, 0); end
    @(posedge clk); #1; rst_n = 1'b1;
    idle(2);
    xfer(0, 2, 0, 0, 0, 0);
    chk("post_rst_done", dc, 5); chk("post_rst_ncen", ncen, 2);
    idle(2);

    // randomized transfers with random backpressure
    for (int t = 0; t < 8; t++) begin
      int ln;
      ln = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
      xfer(int'($urandom_range(0, DEPTH - 1)), ln, 1, 0, 0, 0);
      chk("rnd_ncen", ncen, ln);
      idle(int'($urandom_range(0, 3)));
    end
    // full memory sweep from a random base
    xfer(int'($urandom_range(0, DEPTH - 1)), DEPTH, 1, 0, 0, 0);
    chk("full_ncen", ncen, DEPTH);
    idle(3);
    chk("model_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sram_output_reader.md
Name: sram_output_reader

Overview:
- Read-side drain engine for the output-result SRAM: 1024 x 64-bit words, each word 4 x 16-bit lanes.
- The SRAM is single-port, with active-low chip enable and active-high write enable.
- Reads have 1-cycle latency, and the SRAM data output holds its value while chip enable is deasserted.
- On a start command this block streams a contiguous address range out of the SRAM onto a valid/ready stream with full backpressure support.
- It sits directly downstream of the SRAM; its outputs feed the SRAM's control/address pins and its input takes the SRAM's data_out.

Parameters:
- DATA_WIDTH, 64, SRAM word and stream width.
- ADDR_WIDTH, 10, SRAM address width.
- DEPTH, 1024, SRAM words; addresses wrap modulo DEPTH (power of two).
- FIFO_DEPTH, 4, internal return-buffer entries; minimum 2; 4 or more sustains 1 word/cycle.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset. Assertion is asynchronous; deassertion is synchronised outside this block.
- start  input  1  one-cycle command pulse, sampled only in IDLE.
- base_addr  input  ADDR_WIDTH  first word address, captured with start.
- length  input  ADDR_WIDTH+1  number of words (0..DEPTH), captured with start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse after the final word is handshaken.
- sram_cen_n  output  1  SRAM chip enable, active low, registered.
- sram_wen  output  1  SRAM write enable; tied 0.
- sram_addr  output  ADDR_WIDTH  SRAM address, registered.
- sram_rdata  input  DATA_WIDTH  SRAM data_out.
- out_valid  output  1  stream valid.
- out_ready  input  1  stream ready.
- out_data  output  DATA_WIDTH  stream data = FIFO head.

Behaviour:
- Reset values: sram_cen_n=1, sram_wen=0, sram_addr=0, out_valid=0, out_data=0, busy=0, done=0. FIFO empty, counters 0, state IDLE.
- States:
  - IDLE: start=1 captures base_addr/length.
    - length=0: go to DONE.
    - otherwise: go to RUN.
  - RUN: issue reads and drain the FIFO; go to DONE on the handshake of word length-1.
  - DONE: done=1 for one cycle, then IDLE.
- busy=1 in RUN and DONE, 0 in IDLE. start outside IDLE is ignored (no capture, no effect).
- Issue rule, evaluated each RUN cycle: issue iff words_issued < length AND fifo_count + inflight < FIFO_DEPTH.
  - inflight = reads issued whose data is not yet in the FIFO (0..2).
  - A same-cycle pop gives no credit.
- Issuing registers sram_cen_n=0 and sram_addr=(base_addr+words_issued) mod DEPTH for the next cycle. Otherwise sram_cen_n=1 and sram_addr holds.
- Return path:
  - A 1-bit shift pipe tracks each issued read.
  - The cycle after cen_n=0 is presented, sram_rdata is valid and is pushed into the FIFO at that cycle's edge.
  - A push never overflows, guaranteed by the credit rule; an overflow is a design error and must be flagged by an assertion.
- Latency: start sampled at edge E0 → cen_n=0 during cycle 1 → rdata valid in cycle 2 → out_valid=1 in cycle 3.
- Throughput: with out_ready held 1 and FIFO_DEPTH≥4, one word per cycle, no bubbles after the first.
- Stream rules:
  - out_valid=1 iff FIFO non-empty.
  - out_data is stable while out_valid=1 and out_ready=0.
  - Words leave in address order.
  - Simultaneous push and pop on a non-empty FIFO keeps the count unchanged.
- Wrap-around: address arithmetic is ADDR_WIDTH-bit, so DEPTH-1 is followed by 0. length=DEPTH reads every word exactly once.
- done asserts the cycle after the last handshake. busy drops with done's falling edge (IDLE the cycle after DONE). A start in the DONE cycle is ignored.
- rst_n low mid-operation aborts immediately:
  - All outputs return to reset values asynchronously.
  - FIFO and pipe contents are discarded.
  - No done is produced.
- sram_wen is never 1. The block performs no writes.

Test Plan:
- Preload mem[i]=i; start base=5 len=1, ready=1 → cen_n low exactly 1 cycle with addr=5; out_valid 3 cycles after start, out_data=5; done next cycle; busy 1→0.
- base=0 len=16, ready=1 → 16 consecutive beats 0..15 without gaps; cen_n low 16 consecutive cycles; done one cycle after beat 15.
- base=100 len=20, ready low for cycles 5–12 → no more than FIFO_DEPTH words buffered; cen_n high while credits exhausted; data 100..119 in order, no loss or duplication; out_data stable during stall.
- base=1022 len=4 → sram_addr sequence 1022,1023,0,1; data matches.
- len=0 → no cen_n assertion, no out_valid, done one cycle after start. Also a start pulsed while busy → ignored; the current transfer completes unchanged.
- rst_n pulsed low mid-transfer (after 3 of 10 beats) → outputs at reset values immediately, no done. A new start base=0 len=2 afterwards works normally.
